// File: rtl/wb_sram_slave.sv
// Wishbone slave bridging 32-bit word accesses onto an asynchronous SRAM
// with programmable read/write wait states; every output is registered.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for cyc&stb; latches address/data/select on accept
// S_READ   | oe_n low, counting down READ_WAIT before sampling the pad
// S_WSETUP | address/data settle one cycle before we_n falls
// S_WPULSE | we_n low for WRITE_WAIT cycles, ack on the rising edge
// S_WHOLD  | we_n high, address/data/ce_n still held for one cycle
// S_TURN   | bus turnaround; requests are not sampled here
module wb_sram_slave #(
    parameter int ADDR_W     = 20,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wishbone_cyc_i,
    input  logic              wishbone_stb_i,
    input  logic              wishbone_we_i,
    input  logic [31:0]       wishbone_addr_i,
    input  logic [31:0]       wishbone_data_i,
    input  logic [15:0]       wishbone_select_i,
    output logic [31:0]       wishbone_data_o,
    output logic              wishbone_ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_TURN
    } state_t;

    localparam logic [2:0] RD_INIT = 3'(READ_WAIT - 1);
    localparam logic [2:0] WR_INIT = 3'(WRITE_WAIT - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_abort_q, wr_abort_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              data_oe_q, data_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [3:0]        be_n_q, be_n_d;

    logic req;
    assign req = wishbone_cyc_i & wishbone_stb_i;

    // Address bits outside the SRAM window alias; select[15:4] has no lanes.
    logic unused_bits;
    assign unused_bits = ^{wishbone_addr_i[31:ADDR_W+2], wishbone_addr_i[1:0],
                           wishbone_select_i[15:4]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_abort_d = wr_abort_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_oe_d  = data_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        be_n_d     = be_n_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = wishbone_addr_i[ADDR_W+1:2];
                    be_n_d     = ~wishbone_select_i[3:0];
                    ce_n_d     = 1'b0;
                    wr_abort_d = 1'b0;
                    if (wishbone_we_i) begin
                        wdata_d   = wishbone_data_i;
                        data_oe_d = 1'b1;
                        state_d   = S_WSETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_INIT;
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                if (!wishbone_cyc_i) begin
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    rdata_d = sram_data_i;
                    ack_d   = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_WSETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_INIT;
                state_d = S_WPULSE;
                if (!wishbone_cyc_i) wr_abort_d = 1'b1;
            end

            // The pulse always runs to completion; a dropped cyc only kills the ack.
            S_WPULSE: begin
                if (!wishbone_cyc_i) wr_abort_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    we_n_d  = 1'b1;
                    ack_d   = wishbone_cyc_i & ~wr_abort_q;
                    state_d = S_WHOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_WHOLD: begin
                data_oe_d = 1'b0;
                ce_n_d    = 1'b1;
                be_n_d    = 4'hF;
                state_d   = S_TURN;
            end

            S_TURN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            wr_abort_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            data_oe_q  <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_abort_q <= wr_abort_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_oe_q  <= data_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
        end
    end

    assign wishbone_data_o = rdata_q;
    assign wishbone_ack_o  = ack_q;
    assign sram_addr_o     = addr_q;
    assign sram_data_o     = wdata_q;
    assign sram_data_oe_o  = data_oe_q;
    assign sram_ce_n_o     = ce_n_q;
    assign sram_oe_n_o     = oe_n_q;
    assign sram_we_n_o     = we_n_q;
    assign sram_be_n_o     = be_n_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave with a behavioural async SRAM on the pins.
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [15:0] sel = 16'd0;
    logic [31:0] data_o;
    logic        ack;
    logic [19:0] sram_addr;
    logic [31:0] sram_dout;
    logic [31:0] sram_din;
    logic        data_oe;
    logic        ce_n, oe_n, we_n;
    logic [3:0]  be_n;

    logic [31:0] mem [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_count = 0;
    int          a0;

    wb_sram_slave #(.ADDR_W(20), .READ_WAIT(2), .WRITE_WAIT(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .wishbone_cyc_i    (cyc),
        .wishbone_stb_i    (stb),
        .wishbone_we_i     (we),
        .wishbone_addr_i   (addr),
        .wishbone_data_i   (wdata),
        .wishbone_select_i (sel),
        .wishbone_data_o   (data_o),
        .wishbone_ack_o    (ack),
        .sram_addr_o       (sram_addr),
        .sram_data_o       (sram_dout),
        .sram_data_i       (sram_din),
        .sram_data_oe_o    (data_oe),
        .sram_ce_n_o       (ce_n),
        .sram_oe_n_o       (oe_n),
        .sram_we_n_o       (we_n),
        .sram_be_n_o       (be_n)
    );

    always #5 clk = ~clk;

    assign sram_din = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 32'h0BAD_0BAD;

    // Bytes commit on the rising edge of we_n, as in a real async SRAM.
    always @(posedge we_n) begin
        if (!rst && ce_n === 1'b0) begin
            for (int b = 0; b < 4; b++)
                if (!be_n[b]) mem[sram_addr[7:0]][8*b +: 8] = sram_dout[8*b +: 8];
        end
    end

    always @(negedge clk) if (ack === 1'b1) ack_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [15:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (ce_n !== 1'b1) begin n_bad++; $display("FAIL reset_ce_n: got %b want 1", ce_n); end
        n_cmp++; if (oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
        n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", we_n); end
        n_cmp++; if (be_n !== 4'hF) begin n_bad++; $display("FAIL reset_be_n: got %h want f", be_n); end
        n_cmp++; if (data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_cmp++; if (data_o !== 32'd0) begin n_bad++; $display("FAIL reset_data_o: got %h want 0", data_o); end
        n_cmp++; if (sram_addr !== 20'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
        rst = 1'b0;
        tick();
        n_cmp++; if (ce_n !== 1'b1) begin n_bad++; $display("FAIL idle_ce_n: got %b want 1", ce_n); end
    endtask

    task automatic test_write_read();
        req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h000F);
        tick();
        n_cmp++; if (sram_addr !== 20'h4) begin n_bad++; $display("FAIL wr_addr: got %h want 4", sram_addr); end
        n_cmp++; if (ce_n !== 1'b0) begin n_bad++; $display("FAIL wr_ce_n: got %b want 0", ce_n); end
        n_cmp++; if (data_oe !== 1'b1) begin n_bad++; $display("FAIL wr_data_oe: got %b want 1", data_oe); end
        n_cmp++; if (sram_dout !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_dout: got %h want deadbeef", sram_dout); end
        n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL wr_setup_we_n: got %b want 1", we_n); end
        tick();
        n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL wr_pulse1_we_n: got %b want 0", we_n); end
        n_cmp++; if (be_n !== 4'h0) begin n_bad++; $display("FAIL wr_be_n: got %h want 0", be_n); end
        tick();
        n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL wr_pulse2_we_n: got %b want 0", we_n); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_early_ack: got %b want 0", ack); end
        tick();
        n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL wr_end_we_n: got %b want 1", we_n); end
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wr_ack: got %b want 1", ack); end
        n_cmp++; if (ce_n !== 1'b0 || data_oe !== 1'b1) begin n_bad++; $display("FAIL wr_hold: got ce_n=%b oe=%b want 0 1", ce_n, data_oe); end
        idle_bus();
        tick();
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_width: got %b want 0", ack); end
        n_cmp++; if (data_oe !== 1'b0 || ce_n !== 1'b1 || be_n !== 4'hF) begin n_bad++; $display("FAIL wr_release: got oe=%b ce_n=%b be_n=%h want 0 1 f", data_oe, ce_n, be_n); end
        tick();
        n_cmp++; if (mem[4] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_mem: got %h want deadbeef", mem[4]); end

        req(1'b0, 32'h0000_0010, 32'd0, 16'h000F);
        tick();
        n_cmp++; if (oe_n !== 1'b0 || ack !== 1'b0) begin n_bad++; $display("FAIL rd_start: got oe_n=%b ack=%b want 0 0", oe_n, ack); end
        tick();
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_early_ack: got %b want 0", ack); end
        tick();
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack: got %b want 1", ack); end
        n_cmp++; if (data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", data_o); end
        n_cmp++; if (oe_n !== 1'b1 || ce_n !== 1'b1) begin n_bad++; $display("FAIL rd_release: got oe_n=%b ce_n=%b want 1 1", oe_n, ce_n); end
        idle_bus();
        tick();
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_width: got %b want 0", ack); end
    endtask

    task automatic test_byte_write();
        mem[8] = 32'h1122_3344;
        req(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 16'h0002);
        tick();
        tick();
        n_cmp++; if (we_n !== 1'b0 || be_n !== 4'b1101) begin n_bad++; $display("FAIL bw_be_n: got we_n=%b be_n=%b want 0 1101", we_n, be_n); end
        tick();
        tick();
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL bw_ack: got %b want 1", ack); end
        idle_bus();
        tick();
        tick();
        req(1'b0, 32'h0000_0020, 32'd0, 16'h000F);
        repeat (3) tick();
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL bw_rd_ack: got %b want 1", ack); end
        n_cmp++; if (data_o !== 32'h1122_CC44) begin n_bad++; $display("FAIL bw_rd_data: got %h want 1122cc44", data_o); end
        idle_bus();
        tick();
    endtask

    task automatic test_abort();
        a0 = ack_count;
        req(1'b0, 32'h0000_0010, 32'd0, 16'h000F);
        tick();
        n_cmp++; if (oe_n !== 1'b0) begin n_bad++; $display("FAIL ab_rd_oe_n: got %b want 0", oe_n); end
        idle_bus();
        tick();
        n_cmp++; if (ce_n !== 1'b1 || oe_n !== 1'b1 || be_n !== 4'hF) begin n_bad++; $display("FAIL ab_rd_release: got ce_n=%b oe_n=%b be_n=%h want 1 1 f", ce_n, oe_n, be_n); end
        tick();
        n_cmp++; if (data_o !== 32'h1122_CC44) begin n_bad++; $display("FAIL ab_rd_data_kept: got %h want 1122cc44", data_o); end

        req(1'b1, 32'h0000_0030, 32'h55AA_55AA, 16'h000F);
        tick();
        idle_bus();
        tick();
        n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL ab_wr_pulse1: got %b want 0", we_n); end
        tick();
        n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL ab_wr_pulse2: got %b want 0", we_n); end
        tick();
        n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL ab_wr_end: got %b want 1", we_n); end
        tick();
        tick();
        n_cmp++; if (mem[12] !== 32'h55AA_55AA) begin n_bad++; $display("FAIL ab_wr_mem: got %h want 55aa55aa", mem[12]); end
        n_cmp++; if (ack_count != a0) begin n_bad++; $display("FAIL ab_no_ack: got %0d acks want 0", ack_count - a0); end
    endtask

    task automatic test_held_stb();
        a0 = ack_count;
        req(1'b0, 32'h0000_0010, 32'd0, 16'h000F);
        repeat (3) tick();
        n_cmp++; if (ack !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL hs_ack: got ack=%b data=%h want 1 deadbeef", ack, data_o); end
        tick();
        n_cmp++; if (ack !== 1'b0 || ce_n !== 1'b1) begin n_bad++; $display("FAIL hs_turn: got ack=%b ce_n=%b want 0 1", ack, ce_n); end
        idle_bus();
        tick();
        n_cmp++; if (ce_n !== 1'b1 || oe_n !== 1'b1) begin n_bad++; $display("FAIL hs_no_reaccept: got ce_n=%b oe_n=%b want 1 1", ce_n, oe_n); end
        repeat (3) tick();
        n_cmp++; if (ack_count - a0 != 1) begin n_bad++; $display("FAIL hs_ack_count: got %0d want 1", ack_count - a0); end
    endtask

    task automatic test_sel_zero();
        req(1'b1, 32'hF000_0010, 32'h0000_0000, 16'hFFF0);
        tick();
        n_cmp++; if (sram_addr !== 20'h4) begin n_bad++; $display("FAIL sz_alias_addr: got %h want 4", sram_addr); end
        tick();
        n_cmp++; if (we_n !== 1'b0 || be_n !== 4'hF) begin n_bad++; $display("FAIL sz_be_n: got we_n=%b be_n=%h want 0 f", we_n, be_n); end
        tick();
        tick();
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL sz_ack: got %b want 1", ack); end
        idle_bus();
        tick();
        tick();
        n_cmp++; if (mem[4] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sz_mem: got %h want deadbeef", mem[4]); end
        req(1'b0, 32'h0000_0030, 32'd0, 16'h0000);
        repeat (3) tick();
        n_cmp++; if (ack !== 1'b1 || data_o !== 32'h55AA_55AA) begin n_bad++; $display("FAIL sz_rd: got ack=%b data=%h want 1 55aa55aa", ack, data_o); end
        idle_bus();
        tick();
    endtask

    task automatic test_async_reset();
        req(1'b1, 32'h0000_0040, 32'h1234_5678, 16'h000F);
        tick();
        tick();
        n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL ar_pulse: got %b want 0", we_n); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (we_n !== 1'b1 || data_oe !== 1'b0) begin n_bad++; $display("FAIL ar_immediate: got we_n=%b oe=%b want 1 0", we_n, data_oe); end
        n_cmp++; if (ce_n !== 1'b1 || ack !== 1'b0 || data_o !== 32'd0) begin n_bad++; $display("FAIL ar_state: got ce_n=%b ack=%b data=%h want 1 0 0", ce_n, ack, data_o); end
        idle_bus();
        tick();
        tick();
        rst = 1'b0;
        tick();
        req(1'b0, 32'h0000_0010, 32'd0, 16'h000F);
        tick();
        n_cmp++; if (oe_n !== 1'b0 || ce_n !== 1'b0) begin n_bad++; $display("FAIL ar_new_start: got oe_n=%b ce_n=%b want 0 0", oe_n, ce_n); end
        tick();
        tick();
        n_cmp++; if (ack !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ar_new_read: got ack=%b data=%h want 1 deadbeef", ack, data_o); end
        idle_bus();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_abort();
        test_held_stb();
        test_sel_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
Wishbone responder that ends the CPU's wishbone master port. It maps 32-bit word accesses onto an external asynchronous 32-bit SRAM (ISSI-style, active-low strobes) with programmable wait states. It sits between the SoC bus fabric and the board SRAM pins. Split data buses are used; the top level merges them into the tristate pad.

Parameters:
ADDR_W, 20, SRAM word-address width; wishbone_addr_i[ADDR_W+1:2] is used, upper bits ignored (aliased)
READ_WAIT, 2, cycles oe_n held low before read data is sampled (>=1)
WRITE_WAIT, 2, cycles we_n held low (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wishbone_cyc_i  in  1  bus cycle valid
wishbone_stb_i  in  1  transfer strobe
wishbone_we_i  in  1  1=write, 0=read
wishbone_addr_i  in  32  byte address; bits [1:0] ignored
wishbone_data_i  in  32  write data
wishbone_select_i  in  16  byte enables; [3:0] used, [15:4] ignored
wishbone_data_o  out  32  read data, registered
wishbone_ack_o  out  1  transfer complete, one-cycle pulse
sram_addr_o  out  ADDR_W  SRAM word address
sram_data_o  out  32  data to pad
sram_data_i  in  32  data from pad
sram_data_oe_o  out  1  1=drive pad with sram_data_o
sram_ce_n_o  out  1  chip enable, active-low
sram_oe_n_o  out  1  output enable, active-low
sram_we_n_o  out  1  write enable, active-low
sram_be_n_o  out  4  byte enables, active-low

Behaviour:
- Reset (async, any state): state=IDLE; ack=0, wishbone_data_o=0, sram_addr_o=0, sram_data_o=0, data_oe=0, ce_n=oe_n=we_n=1, be_n=4'hF. All outputs are registered.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, TURN. A 3-bit wait counter is shared.
- IDLE: on an edge where cyc&stb=1, latch addr -> sram_addr_o and be_n = ~select[3:0]; ce_n=0.
  - If we=0: go to READ with oe_n=0 and counter=READ_WAIT-1.
  - If we=1: latch data -> sram_data_o, data_oe=1, and go to WSETUP (we_n stays 1).
- READ: counter decrements each cycle. At counter==0, capture sram_data_i into wishbone_data_o and assert ack for one cycle. At the same edge set ce_n=oe_n=1, be_n=F, and go to TURN.
  - Ack is high READ_WAIT edges after the accept edge.
  - If cyc=0 in any READ cycle: abort to IDLE next edge, strobes released, no ack, data_o unchanged.
- WSETUP: 1 cycle, then we_n=0, counter=WRITE_WAIT-1, go to WPULSE.
- WPULSE: at counter==0, set we_n=1 and go to WHOLD; ack is asserted in this same edge if cyc=1 at that edge.
  - Ack is high WRITE_WAIT+1 edges after the accept edge.
  - A write is never truncated: if cyc drops during WSETUP or WPULSE, the pulse completes and ack is suppressed.
- WHOLD: 1 cycle; data remains driven and ce_n=0 (address/data hold). Then data_oe=0, ce_n=1, be_n=F, go to TURN.
- TURN: 1 idle cycle with ack=0. No new request is sampled here, which prevents re-accepting a stb that the master has not yet dropped. Then go to IDLE.
- Back-to-back accesses: minimum issue interval is READ_WAIT+2 cycles (read) or WRITE_WAIT+4 cycles (write).
- select[3:0]==0 on a write: full timing runs and ack is returned, but no byte is modified (be_n=F). On a read, data is returned with all lanes.
- addr/data/we/select inputs are sampled only in IDLE; later changes are ignored.
- wishbone_data_o holds its last read value until the next read completes.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> ce_n=oe_n=we_n=1, be_n=F, data_oe=0, ack=0, data_o=0.
- Write then read: write addr 0x0000_0010, data 0xDEADBEEF, sel 0xF -> sram_addr_o=4, we_n low for exactly 2 cycles, ack at edge 3 after accept. A subsequent read of 0x10 with SRAM model -> data_o=0xDEADBEEF, ack 2 edges after accept, ack width 1 cycle.
- Byte write: word 0x11223344 pre-stored, write 0xAABBCCDD with sel 0x2 -> be_n=4'b1101 during the pulse; readback 0x1122CC44.
- Read abort: cyc dropped in the first READ cycle -> no ack, strobes released next edge, data_o unchanged. Write abort: cyc dropped in WSETUP -> we_n pulse still 2 cycles, no ack.
- Held stb: master keeps cyc/stb high one cycle past ack -> TURN prevents a second access; exactly one ack per request.
- Async reset mid-write during WPULSE -> we_n=1, data_oe=0 immediately without waiting for clk; next request is processed normally from IDLE.
